// File: rtl/riscv_pkg.sv
// Shared types for the data memory subsystem.
// Access sizes, store buffer entry layout, lane mask helper.
package riscv_pkg;

   localparam int WIDX_W = 30;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b11
   } mem_size_t;

   typedef struct packed {
      logic [WIDX_W-1:0] widx;
      logic [31:0]       data;
      logic [3:0]        mask;
   } sb_entry_t;

   function automatic logic [3:0] size_mask(
      input logic [1:0] sz,
      input logic [1:0] lane
   );
      logic [3:0] m;
      m = 4'b1111;
      if (sz == 2'b00) m = 4'b0001 << lane;
      if (sz == 2'b01) m = 4'b0011 << lane;
      return m;
   endfunction

endpackage

// File: rtl/rv32i_store_buffer.sv
// Circular store buffer with per-lane youngest-wins forwarding.
// Pointers and count reset asynchronously; entry payloads do not.
module rv32i_store_buffer
   import riscv_pkg::*;
#(
   parameter int SB_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDX_W-1:0]          push_widx,
   input  logic [31:0]                push_data,
   input  logic [3:0]                 push_mask,
   input  logic [WIDX_W-1:0]          lk_widx,
   output logic [3:0]                 hit,
   output logic [31:0]                fwd_data,
   output logic [WIDX_W-1:0]          head_widx,
   output logic [31:0]                head_data,
   output logic [3:0]                 head_mask,
   output logic [$clog2(SB_DEPTH):0]  count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = PW + 1;

   sb_entry_t       ent [SB_DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [PW-1:0]   idx;
   logic            do_pop;
   logic            do_push;

   assign empty   = (count == '0);
   assign full    = (count == CW'(SB_DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign head_widx = ent[head].widx;
   assign head_data = ent[head].data;
   assign head_mask = ent[head].mask;

   // Advance pointers and occupancy on push/pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_pop)  head <= head + 1'b1;
         if (do_push) tail <= tail + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Capture the new entry at the tail slot.
   always_ff @(posedge clk) begin
      if (do_push) begin
         ent[tail] <= '{widx: push_widx, data: push_data, mask: push_mask};
      end
   end

   // Walk oldest to youngest so the youngest matching byte wins.
   always_comb begin
      hit      = '0;
      fwd_data = '0;
      idx      = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         idx = head + PW'(i);
         if (CW'(i) < count && ent[idx].widx == lk_widx) begin
            for (int b = 0; b < 4; b++) begin
               if (ent[idx].mask[b]) begin
                  hit[b]            = 1'b1;
                  fwd_data[8*b +: 8] = ent[idx].data[8*b +: 8];
               end
            end
         end
      end
   end

endmodule

// File: rtl/rv32i_dmem_sb.sv
// Data memory with store buffer: loads own the array port,
// stores queue and drain on cycles where the port is idle.
module rv32i_dmem_sb
   import riscv_pkg::*;
#(
   parameter int          MEM_WORDS = 1024,
   parameter int          SB_DEPTH  = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       data_mem_req_i,
   input  logic [31:0]                data_mem_addr_i,
   input  logic [1:0]                 data_mem_byte_en_i,
   input  logic                       data_mem_wr_i,
   input  logic [31:0]                data_mem_wr_data_i,
   output logic [31:0]                data_mem_rd_data_o,
   output logic                       data_mem_err_o,
   output logic [$clog2(SB_DEPTH):0]  sb_count_o,
   output logic                       sb_empty_o
);
   localparam int AW = $clog2(MEM_WORDS);

   logic [31:0]       off;
   logic [WIDX_W-1:0] widx;
   logic [1:0]        lane;
   mem_size_t         sz;
   logic              in_range;
   logic              bad_size;
   logic              ok;
   logic              push;
   logic              pop;
   logic              full;
   logic [3:0]        hit;
   logic [31:0]       fwd_data;
   logic [WIDX_W-1:0] head_widx;
   logic [31:0]       head_data;
   logic [3:0]        head_mask;
   logic [31:0]       arr_word;
   logic [31:0]       ld_word;
   logic [31:0]       mem [MEM_WORDS];
   logic              unused_bits;

   assign off      = data_mem_addr_i - BASE_ADDR;
   assign widx     = off[31:2];
   assign lane     = data_mem_addr_i[1:0];
   assign sz       = mem_size_t'(data_mem_byte_en_i);
   assign in_range = off < 32'(MEM_WORDS * 4);

   assign unused_bits = ^{off[1:0], head_widx[WIDX_W-1:AW]};

   // Alignment check per access size; the unused encoding is an error.
   always_comb begin
      bad_size = 1'b1;
      unique case (1'b1)
         sz == BYTE: bad_size = 1'b0;
         sz == HALF: bad_size = lane[0];
         sz == WORD: bad_size = (lane != 2'b00);
         default:    bad_size = 1'b1;
      endcase
   end

   assign data_mem_err_o = data_mem_req_i & (~in_range | bad_size);
   assign ok             = data_mem_req_i & ~data_mem_err_o;
   assign push           = ok & data_mem_wr_i;
   // Drain whenever the port is free, or make room for a store when full.
   assign pop            = ~sb_empty_o & (~ok | (data_mem_wr_i & full));

   rv32i_store_buffer #(
      .SB_DEPTH (SB_DEPTH)
   ) u_sb (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .push_widx (widx),
      .push_data (data_mem_wr_data_i << {lane, 3'b000}),
      .push_mask (size_mask(data_mem_byte_en_i, lane)),
      .lk_widx   (widx),
      .hit       (hit),
      .fwd_data  (fwd_data),
      .head_widx (head_widx),
      .head_data (head_data),
      .head_mask (head_mask),
      .count     (sb_count_o),
      .full      (full),
      .empty     (sb_empty_o)
   );

   assign arr_word = mem[off[AW+1:2]];

   // Merge forwarded lanes over the array word.
   always_comb begin
      ld_word = arr_word;
      for (int b = 0; b < 4; b++) begin
         if (hit[b]) ld_word[8*b +: 8] = fwd_data[8*b +: 8];
      end
   end

   assign data_mem_rd_data_o = (ok & ~data_mem_wr_i) ? ld_word : '0;

   // Byte-write the drained head entry into the array.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (pop && head_mask[b]) begin
            mem[head_widx[AW-1:0]][8*b +: 8] <= head_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_rv32i_dmem_sb.sv
// Bench for rv32i_dmem_sb: directed vector table, random ops
// against a flat byte-memory model, and reset corner sequences.
module tb_rv32i_dmem_sb;
   localparam int          MW = 1024;
   localparam int          SD = 4;
   localparam logic [31:0] BA = 32'h0000_0000;
   localparam logic [1:0]  SB = 2'b00;
   localparam logic [1:0]  SH = 2'b01;
   localparam logic [1:0]  SWD = 2'b11;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  sz = 2'b00;
   logic [31:0] addr = '0;
   logic [31:0] wd = '0;
   logic [31:0] rd;
   logic        err;
   logic [2:0]  cnt;
   logic        empty;

   int checks = 0;
   int failures = 0;
   logic [7:0] mdl [MW*4];
   int mcnt = 0;

   typedef struct packed {
      bit          rq;
      bit          w;
      logic [1:0]  s;
      logic [31:0] a;
      logic [31:0] d;
      bit          crd;
      logic [31:0] erd;
      bit          eerr;
      logic [2:0]  ecnt;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   rv32i_dmem_sb #(
      .MEM_WORDS (MW),
      .SB_DEPTH  (SD),
      .BASE_ADDR (BA)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .data_mem_req_i     (req),
      .data_mem_addr_i    (addr),
      .data_mem_byte_en_i (sz),
      .data_mem_wr_i      (wr),
      .data_mem_wr_data_i (wd),
      .data_mem_rd_data_o (rd),
      .data_mem_err_o     (err),
      .sb_count_o         (cnt),
      .sb_empty_o         (empty)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(bit rq, bit w, logic [1:0] s,
      logic [31:0] a, logic [31:0] d, bit crd, logic [31:0] erd,
      bit eerr, logic [2:0] ecnt);
      return '{rq, w, s, a, d, crd, erd, eerr, ecnt};
   endfunction

   function automatic bit m_err(bit rq, logic [1:0] s, logic [31:0] a);
      logic [31:0] o;
      o = a - BA;
      if (!rq) return 1'b0;
      if (o >= 32'(MW*4)) return 1'b1;
      case (s)
         2'b00:   return 1'b0;
         2'b01:   return a[0];
         2'b11:   return a[1:0] != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   // One request cycle: returns observed values and model expectations.
   task automatic op(input bit rq, input bit w, input logic [1:0] s,
      input logic [31:0] a, input logic [31:0] d,
      output logic [31:0] o_rd, output logic o_err, output int o_cnt,
      output logic [31:0] e_rd, output logic e_err, output int e_cnt);
      logic [31:0] off;
      int n;
      @(negedge clk);
      req = rq; wr = w; sz = s; addr = a; wd = d;
      #1;
      o_rd = rd;
      o_err = err;
      off = a - BA;
      e_err = m_err(rq, s, a);
      e_rd = '0;
      if (rq && !e_err && !w)
         for (int k = 0; k < 4; k++)
            e_rd[8*k +: 8] = mdl[{off[31:2], 2'b00} + 32'(k)];
      if (rq && !e_err && w) begin
         n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
         for (int k = 0; k < n; k++) mdl[off + 32'(k)] = d[8*k +: 8];
         mcnt = (mcnt < SD) ? mcnt + 1 : SD;
      end else if (!(rq && !e_err) && mcnt > 0) begin
         mcnt--;
      end
      e_cnt = mcnt;
      @(posedge clk);
      #1;
      o_cnt = int'(cnt);
   endtask

   initial begin
      logic [31:0] o_rd, e_rd;
      logic        o_err, e_err;
      int          o_cnt, e_cnt;
      bit          rq, w;
      logic [1:0]  s;
      logic [31:0] a;
      int          r;

      foreach (mdl[i]) mdl[i] = 8'h00;

      #7;
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_rd", rd, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 64; i++) begin
         op(1, 1, SWD, 32'(i*4), 32'd0, o_rd, o_err, o_cnt, e_rd, e_err, e_cnt);
         op(0, 0, SWD, 32'd0, 32'd0, o_rd, o_err, o_cnt, e_rd, e_err, e_cnt);
      end

      tbl.push_back(mk(1,1,SWD,32'h10,32'hDEADBEEF,0,0,0,1));
      tbl.push_back(mk(1,0,SWD,32'h10,0,1,32'hDEADBEEF,0,1));
      tbl.push_back(mk(0,0,SWD,0,0,1,0,0,0));
      tbl.push_back(mk(1,0,SWD,32'h10,0,1,32'hDEADBEEF,0,0));
      tbl.push_back(mk(1,1,SWD,32'h20,32'h11223344,0,0,0,1));
      tbl.push_back(mk(0,0,SWD,0,0,1,0,0,0));
      tbl.push_back(mk(1,1,SB,32'h21,32'h123456AA,0,0,0,1));
      tbl.push_back(mk(1,1,SB,32'h21,32'h00000055,0,0,0,2));
      tbl.push_back(mk(1,0,SWD,32'h20,0,1,32'h11225544,0,2));
      tbl.push_back(mk(0,0,SWD,0,0,1,0,0,1));
      tbl.push_back(mk(0,0,SWD,0,0,1,0,0,0));
      tbl.push_back(mk(1,0,SWD,32'h20,0,1,32'h11225544,0,0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1,1,SWD,32'(i*4),32'(i+1),0,0,0,
                          3'((i < 4) ? i + 1 : 4)));
      tbl.push_back(mk(1,0,SWD,32'h0,0,1,32'd1,0,4));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0,0,SWD,0,0,1,0,0,3'(3 - i)));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1,0,SWD,32'(i*4),0,1,32'(i+1),0,0));
      tbl.push_back(mk(1,1,SH,32'h12,32'h0000BEEF,0,0,0,1));
      tbl.push_back(mk(1,0,SWD,32'h10,0,1,32'hBEEF0005,0,1));
      tbl.push_back(mk(1,0,SH,32'h12,0,1,32'hBEEF0005,0,1));
      tbl.push_back(mk(0,0,SWD,0,0,1,0,0,0));
      tbl.push_back(mk(1,0,SWD,32'h2,0,1,0,1,0));
      tbl.push_back(mk(1,1,SH,32'h3,32'h1234,1,0,1,0));
      tbl.push_back(mk(1,1,SWD,BA + 32'(MW*4),32'h99,0,0,1,0));
      tbl.push_back(mk(1,0,SWD,BA + 32'(MW*4),0,1,0,1,0));
      tbl.push_back(mk(1,0,2'b10,32'h0,0,1,0,1,0));
      tbl.push_back(mk(1,1,SWD,32'hFFC,32'hA5A5A5A5,0,0,0,1));
      tbl.push_back(mk(1,0,SWD,32'hFFC,0,1,32'hA5A5A5A5,0,1));
      tbl.push_back(mk(1,1,SWD,32'h30,32'h77,0,0,0,2));
      tbl.push_back(mk(1,1,SH,32'h3,32'h1,1,0,1,1));
      tbl.push_back(mk(0,0,SWD,0,0,1,0,0,0));
      tbl.push_back(mk(1,0,SWD,32'h30,0,1,32'h77,0,0));
      tbl.push_back(mk(1,0,SWD,32'hFFC,0,1,32'hA5A5A5A5,0,0));

      foreach (tbl[i]) begin
         op(tbl[i].rq, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d,
            o_rd, o_err, o_cnt, e_rd, e_err, e_cnt);
         chk($sformatf("vec%0d_err", i), 32'(o_err), 32'(tbl[i].eerr));
         if (tbl[i].crd)
            chk($sformatf("vec%0d_rd", i), o_rd, tbl[i].erd);
         chk($sformatf("vec%0d_cnt", i), 32'(o_cnt), 32'(tbl[i].ecnt));
      end

      for (int i = 0; i < 300; i++) begin
         r  = int'($urandom_range(0, 99));
         rq = (r >= 20);
         w  = $urandom_range(0, 1) == 1;
         r  = int'($urandom_range(0, 19));
         s  = (r == 0) ? 2'b10 : (r < 7) ? SB : (r < 13) ? SH : SWD;
         a  = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 19) == 0) a = a + 32'(MW*4);
         op(rq, w, s, a, $urandom, o_rd, o_err, o_cnt, e_rd, e_err, e_cnt);
         chk($sformatf("rnd%0d_err", i), 32'(o_err), 32'(e_err));
         if (!rq || !w)
            chk($sformatf("rnd%0d_rd", i), o_rd, e_rd);
         chk($sformatf("rnd%0d_cnt", i), 32'(o_cnt), 32'(e_cnt));
         chk($sformatf("rnd%0d_empty", i), 32'(empty), 32'(e_cnt == 0));
      end

      for (int i = 0; i < SD; i++)
         op(0, 0, SWD, 0, 0, o_rd, o_err, o_cnt, e_rd, e_err, e_cnt);
      chk("rnd_drained", 32'(cnt), 32'd0);

      op(1, 1, SWD, 32'h40, 32'h0, o_rd, o_err, o_cnt, e_rd, e_err, e_cnt);
      op(0, 0, SWD, 0, 0, o_rd, o_err, o_cnt, e_rd, e_err, e_cnt);
      op(1, 1, SWD, 32'h40, 32'hCAFE0000, o_rd, o_err, o_cnt, e_rd, e_err, e_cnt);
      op(1, 1, SWD, 32'h44, 32'h1, o_rd, o_err, o_cnt, e_rd, e_err, e_cnt);
      op(1, 1, SWD, 32'h48, 32'h2, o_rd, o_err, o_cnt, e_rd, e_err, e_cnt);
      chk("pre_rst_cnt", 32'(o_cnt), 32'd3);
      op(1, 0, SWD, 32'h40, 0, o_rd, o_err, o_cnt, e_rd, e_err, e_cnt);
      chk("pre_rst_fwd", o_rd, 32'hCAFE0000);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_cnt", 32'(cnt), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      req = 1'b0;
      #1;
      chk("arst_rd_idle", rd, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      op(1, 0, SWD, 32'h40, 0, o_rd, o_err, o_cnt, e_rd, e_err, e_cnt);
      chk("post_rst_lw", o_rd, 32'd0);
      chk("post_rst_cnt", 32'(o_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
